sipo_shift_reg_4bit: RTL and testbench



---
 rtl/sipo_shift_reg_4bit.sv | 23 ++
 tb/tb_sipo_shift_reg_4bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_reg_4bit.sv
// 4-bit serial-in, parallel-out shift register.
// Collects a 1-bit serial stream into a nibble, newest bit in bit 0.
module sipo_shift_reg_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [3:0] parallel_out
);

  logic [3:0] shift_r;

  // Sliding window: reset clears, otherwise shift left with the new bit entering bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 4'b0000;
    end else begin
      shift_r <= {shift_r[2:0], serial_in};
    end
  end

  assign parallel_out = shift_r;

endmodule

// File: tb/tb_sipo_shift_reg_4bit.sv
// Self-checking bench for sipo_shift_reg_4bit: expected nibbles are queued as
// stimulus is driven and compared after each rising edge.
module tb_sipo_shift_reg_4bit;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [3:0] parallel_out;

  logic [3:0] sb[$];
  int vectors;
  int miscompares;

  sipo_shift_reg_4bit dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .parallel_out (parallel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Change inputs at the negedge, queue the expectation, then step past the rising edge.
  task automatic drive(input logic rst, input logic din, input logic [3:0] exp);
    @(negedge clk);
    reset     = rst;
    serial_in = din;
    sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] want;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 4'h0);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL reset[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_reference_stream();
    logic [9:0]  bits;
    logic [39:0] exps;
    logic [3:0]  want;
    bits = 10'b1011101000;
    exps = 40'h125B7EDA48;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, bits[9-i], exps[39-4*i -: 4]);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL ref_stream[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_fill_ones();
    logic [6:0]  bits;
    logic [27:0] exps;
    logic [3:0]  want;
    bits = 7'b0111110;
    exps = 28'h0137FFE;
    for (int i = 0; i < 7; i++) begin
      drive((i == 0) ? 1'b1 : 1'b0, bits[6-i], exps[27-4*i -: 4]);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL fill_ones[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_bit_walk();
    logic [5:0]  bits;
    logic [23:0] exps;
    logic [3:0]  want;
    bits = 6'b010000;
    exps = 24'h012480;
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? 1'b1 : 1'b0, bits[5-i], exps[23-4*i -: 4]);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL bit_walk[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [6:0]  rsts;
    logic [6:0]  bits;
    logic [27:0] exps;
    logic [3:0]  want;
    rsts = 7'b1000010;
    bits = 7'b1110111;
    exps = 28'h0136D01;
    for (int i = 0; i < 7; i++) begin
      drive(rsts[6-i], bits[6-i], exps[27-4*i -: 4]);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL midstream_reset[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [5:0]  rsts;
    logic [23:0] exps;
    logic [3:0]  want;
    rsts = 6'b100001;
    exps = 24'h0137F0;
    for (int i = 0; i < 6; i++) begin
      drive(rsts[5-i], 1'b1, exps[23-4*i -: 4]);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL reset_priority[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  // Random stream checked against an independent sliding-window history of sampled bits.
  task automatic test_back_to_back();
    logic [3:0] want;
    logic       hist[$];
    logic       b;
    logic [3:0] exp;
    drive(1'b1, 1'b1, 4'h0);
    want = sb.pop_front();
    vectors++;
    if (parallel_out !== want) begin
      $display("FAIL b2b_reset: got %h, expected %h", parallel_out, want);
      miscompares++;
    end
    for (int i = 0; i < 40; i++) begin
      b = 1'($urandom_range(1, 0));
      hist.push_back(b);
      exp = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (hist.size() > k) exp[k] = hist[hist.size() - 1 - k];
      end
      drive(1'b0, b, exp);
      want = sb.pop_front();
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL back_to_back[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
      #3;
      vectors++;
      if (parallel_out !== want) begin
        $display("FAIL hold_between_edges[%0d]: got %h, expected %h", i, parallel_out, want);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    serial_in   = 1'b0;
    test_reset();
    test_reference_stream();
    test_fill_ones();
    test_single_bit_walk();
    test_midstream_reset();
    test_reset_priority();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
